// File: rtl/global_types.sv
// Shared types and constants for the MIPS unified-memory port arbiter.
package global_types;

  localparam int MEM_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    ACK
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational owner selection: data wins ties unless the waiting fetch has
// been passed over MAX_STREAK times in a row.
module arb_pick
  import global_types::*;
#(
  parameter int MAX_STREAK = 4,
  parameter int SW         = $clog2(MAX_STREAK + 1)
) (
  input  logic          i_req,
  input  logic          d_req,
  input  logic [SW-1:0] streak,
  output arb_owner_t    owner
);

  always_comb begin
    owner = OWN_D;
    if (i_req && (!d_req || streak == SW'(MAX_STREAK))) begin
      owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port unified memory between the fetch and data ports,
// one outstanding transaction at a time.
module mem_port_arbiter
  import global_types::*;
#(
  parameter int AW         = 10,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [AW-1:0]         i_addr,
  output logic                  i_ack,
  output logic [MEM_WORD_W-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [AW-1:0]         d_addr,
  input  logic [MEM_WORD_W-1:0] d_wdata,
  output logic                  d_ack,
  output logic [MEM_WORD_W-1:0] d_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [AW-1:0]         m_addr,
  output logic [MEM_WORD_W-1:0] m_wdata,
  input  logic [MEM_WORD_W-1:0] m_rdata,
  output logic                  busy
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int LW = 3;

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, pick_owner;
  logic [AW-1:0]         addr_q;
  logic                  we_q;
  logic [MEM_WORD_W-1:0] wdata_q;
  logic [SW-1:0]         streak_q;
  logic [LW-1:0]         lat_q;
  logic [MEM_WORD_W-1:0] i_rdata_q, d_rdata_q;
  logic                  any_req;

  assign any_req = i_req | d_req;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

  arb_pick #(
    .MAX_STREAK (MAX_STREAK),
    .SW         (SW)
  ) u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .streak (streak_q),
    .owner  (pick_owner)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reads always pass through WAIT; with MEM_LAT=1 it is just the capture cycle.
  always_comb begin
    state_d = state_q;
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (any_req) state_d = ACCESS;
      end
      ACCESS: begin
        m_en    = 1'b1;
        m_we    = we_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        state_d = we_q ? ACK : WAIT;
      end
      WAIT: begin
        if (lat_q == '0) state_d = ACK;
      end
      ACK: begin
        i_ack   = (owner_q == OWN_I);
        d_ack   = (owner_q == OWN_D);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q   <= OWN_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      streak_q  <= '0;
      lat_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!i_req || pick_owner == OWN_I) begin
            streak_q <= '0;
          end else if (streak_q != SW'(MAX_STREAK)) begin
            streak_q <= streak_q + SW'(1);
          end
          if (any_req) begin
            owner_q <= pick_owner;
            if (pick_owner == OWN_I) begin
              addr_q  <= i_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end else begin
              addr_q  <= d_addr;
              we_q    <= d_we;
              wdata_q <= d_wdata;
            end
          end
        end
        ACCESS: begin
          lat_q <= LW'(MEM_LAT - 1);
        end
        WAIT: begin
          if (lat_q == '0) begin
            if (owner_q == OWN_I) i_rdata_q <= m_rdata;
            else                  d_rdata_q <= m_rdata;
          end else begin
            lat_q <= lat_q - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
